// File: rtl/gain_divider_pkg.sv
// Shared types and constants for the gain divider.
// Includes the saturated quotient that is returned on a divide by zero.
package gain_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ATTEN_W  = 8;
    localparam int SAMPLE_W = 16;

    // Most positive value for a non-negative dividend, most negative otherwise (widths up to 32).
    function automatic logic [31:0] sat_quot(input logic neg, input int unsigned w);
        logic [31:0] max_pos;
        max_pos = (32'd1 << (w - 32'd1)) - 32'd1;
        return neg ? ~max_pos : max_pos;
    endfunction

endpackage

// File: rtl/gain_divider_if.sv
// Operand and result handshake bundle for the gain divider.
// slave is the divider side and master is the producer/consumer side.
interface gain_divider_if
    import gain_div_pkg::*;
#(
    parameter int N = SAMPLE_W
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic signed [N-1:0]      data_i;
    logic [ATTEN_W-1:0]       atten_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic signed [N-1:0]      quot_o;
    logic signed [N-1:0]      rem_o;
    logic                     div0_o;

    modport slave (
        input  in_valid_i, data_i, atten_i, out_ready_i,
        output in_ready_o, out_valid_o, quot_o, rem_o, div0_o
    );

    modport master (
        output in_valid_i, data_i, atten_i, out_ready_i,
        input  in_ready_o, out_valid_o, quot_o, rem_o, div0_o
    );
endinterface

// File: rtl/gain_divider_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module gain_div_step
    import gain_div_pkg::*;
#(
    parameter int N = SAMPLE_W
) (
    input  logic [N:0]         r_i,
    input  logic [N-1:0]       q_i,
    input  logic [ATTEN_W-1:0] d_i,
    output logic [N:0]         r_o,
    output logic [N-1:0]       q_o
);
    logic [N+1:0] r_shift_s;
    logic [N+1:0] d_ext_s;
    logic         fits_s;

    // Shift, compare and conditionally subtract.
    always_comb begin
        r_shift_s = {r_i, q_i[N-1]};
        d_ext_s   = {{(N+2-ATTEN_W){1'b0}}, d_i};
        fits_s    = (r_shift_s >= d_ext_s);
        if (fits_s) begin
            r_o = (N+1)'(r_shift_s - d_ext_s);
        end else begin
            r_o = (N+1)'(r_shift_s);
        end
        q_o = {q_i[N-2:0], fits_s};
    end
endmodule

// File: rtl/gain_divider.sv
// Iterative signed-by-unsigned divider, one quotient bit per clock.
// Works on magnitudes and restores the dividend sign on quotient and remainder.
module gain_divider
    import gain_div_pkg::*;
#(
    parameter int N = SAMPLE_W
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    gain_divider_if.slave bus
);
    localparam int CNT_W = $clog2(N);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [ATTEN_W-1:0]   d_q, d_d;
    logic [N:0]           r_q, r_d;
    logic [N-1:0]         q_q, q_d;
    logic [N-1:0]         quot_q, quot_d;
    logic [N-1:0]         rem_q, rem_d;
    logic                 div0_q, div0_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [N:0]           step_r_s;
    logic [N-1:0]         step_q_s;

    gain_div_step #(.N(N)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r_s),
        .q_o (step_q_s)
    );

    // Next-state, datapath and output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        d_d         = d_q;
        r_d         = r_q;
        q_d         = q_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div0_d      = div0_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    neg_d = bus.data_i[N-1];
                    // Unsigned magnitude: the most negative sample maps to 2^(N-1).
                    q_d   = bus.data_i[N-1] ? ({N{1'b0}} - bus.data_i) : bus.data_i;
                    r_d   = {(N+1){1'b0}};
                    d_d   = bus.atten_i;
                    cnt_d = CNT_W'(N - 1);
                    if (bus.atten_i == {ATTEN_W{1'b0}}) begin
                        quot_d  = N'(sat_quot(bus.data_i[N-1], N));
                        rem_d   = {N{1'b0}};
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                r_d   = step_r_s;
                q_d   = step_q_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == {CNT_W{1'b0}}) begin
                    quot_d  = neg_q ? ({N{1'b0}} - step_q_s) : step_q_s;
                    rem_d   = neg_q ? ({N{1'b0}} - step_r_s[N-1:0]) : step_r_s[N-1:0];
                    div0_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            neg_q       <= 1'b0;
            d_q         <= {ATTEN_W{1'b0}};
            r_q         <= {(N+1){1'b0}};
            q_q         <= {N{1'b0}};
            quot_q      <= {N{1'b0}};
            rem_q       <= {N{1'b0}};
            div0_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            d_q         <= d_d;
            r_q         <= r_d;
            q_q         <= q_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            div0_q      <= div0_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.quot_o      = quot_q;
    assign bus.rem_o       = rem_q;
    assign bus.div0_o      = div0_q;
endmodule

// File: tb/tb_gain_divider.sv
// Directed and randomised checks of gain_divider against hand-computed values
// and a truncating-division model.
module tb_gain_divider;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   acc_cnt;
    int   out_cnt;
    int   last_acc;
    int   prev_acc;

    gain_divider_if #(.N(16)) bus ();

    gain_divider #(.N(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor: cycle count, accepts and delivered results.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.in_valid_i && bus.in_ready_o) begin
                acc_cnt  <= acc_cnt + 1;
                prev_acc <= last_acc;
                last_acc <= cyc;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                out_cnt <= out_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic signed [15:0] a, input logic [7:0] b,
                         output logic signed [15:0] q, output logic signed [15:0] r,
                         output logic z, output int lat);
        int ai;
        int bi;
        ai = a;
        bi = b;
        if (b == 8'd0) begin
            q   = (a < 16'sd0) ? 16'sh8000 : 16'sd32767;
            r   = 16'sd0;
            z   = 1'b1;
            lat = 1;
        end else begin
            q   = 16'(ai / bi);
            r   = 16'(ai % bi);
            z   = 1'b0;
            lat = 17;
        end
    endtask

    // Issue one operand pair, check latency and result, then accept after 'hold' stalled cycles.
    task automatic do_op(input string tag, input logic signed [15:0] a, input logic [7:0] b,
                         input logic signed [15:0] eq, input logic signed [15:0] er,
                         input logic ez, input int elat, input int hold);
        int lat;
        int w;
        logic signed [15:0] q0;
        w = 0;
        while (!bus.in_ready_o && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready_o) chk({tag, " ready_timeout"}, 0, 1);
        bus.in_valid_i = 1'b1;
        bus.data_i     = a;
        bus.atten_i    = b;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        lat = 1;
        while (!bus.out_valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " quot"}, $signed(bus.quot_o), eq);
        chk({tag, " rem"}, $signed(bus.rem_o), er);
        chk({tag, " div0"}, bus.div0_o, ez);
        q0 = bus.quot_o;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid_i = 1'b1;
            bus.data_i     = 16'sh1111;
            bus.atten_i    = 8'd3;
            @(posedge clk); #1;
            chk({tag, " hold_quot"}, $signed(bus.quot_o), q0);
            chk({tag, " hold_ready"}, bus.in_ready_o, 0);
            chk({tag, " hold_valid"}, bus.out_valid_o, 1);
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        chk({tag, " ready_after_accept"}, bus.in_ready_o, 1);
        chk({tag, " valid_after_accept"}, bus.out_valid_o, 0);
    endtask

    initial begin
        logic signed [15:0] a;
        logic [7:0]         b;
        logic signed [15:0] eq;
        logic signed [15:0] er;
        logic               ez;
        int                 elat;
        int                 acc0;
        int                 out0;
        n_cmp = 0; n_err = 0;
        cyc = 0; acc_cnt = 0; out_cnt = 0; last_acc = 0; prev_acc = 0;
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.data_i      = 16'sd0;
        bus.atten_i     = 8'd0;
        bus.out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst in_ready", bus.in_ready_o, 1);
        chk("rst out_valid", bus.out_valid_o, 0);
        chk("rst quot", $signed(bus.quot_o), 0);
        chk("rst rem", $signed(bus.rem_o), 0);
        chk("rst div0", bus.div0_o, 0);

        do_op("1000/7",    16'sd1000,   8'd7,   16'sd142,   16'sd6,   1'b0, 17, 0);
        do_op("-1000/7",  -16'sd1000,   8'd7,  -16'sd142,  -16'sd6,   1'b0, 17, 0);
        do_op("-32768/1",  16'sh8000,   8'd1,   16'sh8000,  16'sd0,   1'b0, 17, 0);
        do_op("32767/255", 16'sd32767,  8'd255, 16'sd128,   16'sd127, 1'b0, 17, 0);
        do_op("-7/2",     -16'sd7,      8'd2,  -16'sd3,    -16'sd1,   1'b0, 17, 0);
        do_op("5/255",     16'sd5,      8'd255, 16'sd0,     16'sd5,   1'b0, 17, 0);
        do_op("0/5",       16'sd0,      8'd5,   16'sd0,     16'sd0,   1'b0, 17, 0);
        do_op("1234/0",    16'sd1234,   8'd0,   16'sd32767, 16'sd0,   1'b1, 1,  0);
        do_op("bp 1000/7", 16'sd1000,   8'd7,   16'sd142,   16'sd6,   1'b0, 17, 5);
        do_op("-5/0",     -16'sd5,      8'd0,   16'sh8000,  16'sd0,   1'b1, 1,  0);

        // Reset in the middle of a calculation.
        bus.in_valid_i = 1'b1;
        bus.data_i     = 16'sd1000;
        bus.atten_i    = 8'd7;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst in_ready", bus.in_ready_o, 1);
        chk("midrst out_valid", bus.out_valid_o, 0);
        chk("midrst quot", $signed(bus.quot_o), 0);
        chk("midrst rem", $signed(bus.rem_o), 0);
        chk("midrst div0", bus.div0_o, 0);
        repeat (20) @(posedge clk);
        #1 chk("midrst discarded", bus.out_valid_o, 0);
        do_op("100/3", 16'sd100, 8'd3, 16'sd33, 16'sd1, 1'b0, 17, 0);

        // Throughput with both sides always ready.
        bus.in_valid_i  = 1'b1;
        bus.data_i      = 16'sd1000;
        bus.atten_i     = 8'd7;
        bus.out_ready_i = 1'b1;
        repeat (40) @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        chk("throughput period", last_acc - prev_acc, 18);
        chk("throughput in_ready", bus.in_ready_o, 1);

        // Random operands with random output stalls.
        acc0 = acc_cnt;
        out0 = out_cnt;
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            model(a, b, eq, er, ez, elat);
            do_op("rand", a, b, eq, er, ez, elat, $urandom_range(0, 3));
        end
        #1;
        chk("rand accepts", acc_cnt - acc0, 25);
        chk("rand results", out_cnt - out0, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
